// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and the hex-to-segment table for the seg7 scan
// controller.
//   state_t     scan FSM state (BLANK, DRIVE)
//   SEG_OFF     all cathodes released (active-low)
//   AN_OFF      all anodes released (active-low)
//   hex_to_seg  4-bit hex digit -> active-low segments, bit0=CA ... bit6=CG
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_upd_if: valid/ready update port of the seg7 scan controller.
//   upd_valid  update request (master -> slave)
//   upd_ready  shadow register free (slave -> master)
//   upd_value  four hex digits, [3:0] -> AN0 ... [15:12] -> AN3
//   upd_dp     decimal point per digit, 1 = lit
//   upd_blank  digit blank mask, 1 = digit dark
interface seg7_upd_if;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_value;
  logic [3:0]  upd_dp;
  logic [3:0]  upd_blank;

  modport master (
    output upd_valid, upd_value, upd_dp, upd_blank,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_value, upd_dp, upd_blank,
    output upd_ready
  );
endinterface

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: combinational hex digit to active-low segment decoder.
//   hex  in   4  hex digit
//   seg  out  7  active-low segments, seg[0]=CA ... seg[6]=CG
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a 4-digit
// common-anode 7-segment display, with per-slot dead time and a shadowed
// valid/ready update port applied at frame boundaries.
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   upd         update port (seg7_upd_if.slave)
//   an          anodes, active-low, an[i] -> ANi
//   seg         cathodes, active-low, seg[0]=CA ... seg[6]=CG
//   dp          decimal-point cathode, active-low
//   frame_done  one-cycle pulse on the last cycle of digit 3's slot
// Build option: define SEG7_LZS_EN to blank leading zero digits (AN0 is
// never suppressed).
//
//   state | meaning
//   BLANK | all anodes off for BLANK_CYC cycles at the start of a slot
//   DRIVE | anode idx on (unless blanked) until the end of the slot
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_upd_if.slave        upd,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             dp,
  output logic             frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  // frame_done is registered, so it is launched one cycle before the wrap
  localparam logic [CW-1:0] PRE_LAST   = CW'(PRESCALE - 2);

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [1:0]      idx, idx_nx;
  logic            wrap;

  logic [15:0]     act_value, sh_value;
  logic [3:0]      act_dp, sh_dp;
  logic [3:0]      act_blank, sh_blank;
  logic            sh_full;
  logic            ready_q;

  logic [3:0]      digit;
  logic [6:0]      seg_dec;
  logic [3:0]      an_sel;
  logic [3:0]      lz_mask;
  logic            dark;
  logic [3:0]      an_nx;
  logic [6:0]      seg_nx;
  logic            dp_nx;
  logic            fd_nx;

  assign upd.upd_ready = ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= 2'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    idx_nx   = idx;
    wrap     = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) state_nx = DRIVE;
      end
      DRIVE: begin
        if (cnt == SLOT_LAST) begin
          cnt_nx   = '0;
          idx_nx   = idx + 2'd1;
          state_nx = BLANK;
          wrap     = (idx == 2'd3);
        end
      end
      default: state_nx = BLANK;
    endcase
  end

  // ready_q always mirrors an empty shadow, so an accept and a shadow
  // copy can never happen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_value <= 16'h0000;
      act_dp    <= 4'h0;
      act_blank <= 4'hF;
      sh_value  <= 16'h0000;
      sh_dp     <= 4'h0;
      sh_blank  <= 4'h0;
      sh_full   <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      if (upd.upd_valid && ready_q) begin
        sh_value <= upd.upd_value;
        sh_dp    <= upd.upd_dp;
        sh_blank <= upd.upd_blank;
        sh_full  <= 1'b1;
        ready_q  <= 1'b0;
      end else if (wrap && sh_full) begin
        act_value <= sh_value;
        act_dp    <= sh_dp;
        act_blank <= sh_blank;
        sh_full   <= 1'b0;
        ready_q   <= 1'b1;
      end
    end
  end

`ifdef SEG7_LZS_EN
  assign lz_mask = {act_value[15:12] == 4'h0,
                    act_value[15:8]  == 8'h00,
                    act_value[15:4]  == 12'h000,
                    1'b0};
`else
  assign lz_mask = 4'h0;
`endif

  always_comb begin
    digit  = act_value[3:0];
    an_sel = 4'b1110;
    case (idx)
      2'd0: begin digit = act_value[3:0];   an_sel = 4'b1110; end
      2'd1: begin digit = act_value[7:4];   an_sel = 4'b1101; end
      2'd2: begin digit = act_value[11:8];  an_sel = 4'b1011; end
      default: begin digit = act_value[15:12]; an_sel = 4'b0111; end
    endcase
  end

  seg7_hex_decoder u_dec (
    .hex (digit),
    .seg (seg_dec)
  );

  always_comb begin
    dark   = act_blank[idx] | lz_mask[idx];
    an_nx  = AN_OFF;
    seg_nx = SEG_OFF;
    dp_nx  = 1'b1;
    if (state == DRIVE && !dark) begin
      an_nx  = an_sel;
      seg_nx = seg_dec;
      dp_nx  = ~act_dp[idx];
    end
    fd_nx = (idx == 2'd3) && (cnt == PRE_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nx;
      seg        <= seg_nx;
      dp         <= dp_nx;
      frame_done <= fd_nx;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: scoreboard bench for seg7_scan_ctrl (PRESCALE=8,
// BLANK_CYC=2). Stimulus pushes the expected content of each displayed
// frame; a monitor rebuilds every frame from the pins and pops/compares.
module tb_seg7_scan_ctrl;

  localparam int PRESCALE  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 4 * PRESCALE;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;
  typedef slot_t [3:0] frame_t;

  localparam slot_t DARK = {4'hF, 7'h7F, 1'b1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  seg7_upd_if upd_bus();

  seg7_scan_ctrl #(.PRESCALE(PRESCALE), .BLANK_CYC(BLANK_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd        (upd_bus),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc;
  frame_t exp_q[$];

  // Cycle number since the last reset release; cycle 0 precedes the first edge.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic slot_t sl(input logic [3:0] a, input logic [6:0] s, input logic d);
    return {a, s, d};
  endfunction

  function automatic frame_t mk(input slot_t s0, input slot_t s1, input slot_t s2, input slot_t s3);
    return {s3, s2, s1, s0};
  endfunction

  // Monitor: output frame f occupies cycles FRAME*f+1 .. FRAME*f+FRAME.
  slot_t  obs [4];
  logic   shape_ok [4];
  slot_t  cur;
  frame_t mon_exp;
  int     mp, ms, mw;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done || (cyc % FRAME == FRAME - 1))
        chk("frame_done timing", frame_done, (cyc % FRAME == FRAME - 1));
      if (cyc >= 1) begin
        mp  = (cyc - 1) % FRAME;
        ms  = mp / PRESCALE;
        mw  = mp % PRESCALE;
        cur = {an, seg, dp};
        if (mw == 0) shape_ok[ms] = 1'b1;
        if (mw < BLANK_CYC) begin
          if (cur !== DARK) shape_ok[ms] = 1'b0;
        end else if (mw == BLANK_CYC) begin
          obs[ms] = cur;
        end else if (cur !== obs[ms]) begin
          shape_ok[ms] = 1'b0;
        end
        if (mp == FRAME - 1) begin
          if (exp_q.size() == 0) begin
            chk("expectation queued", 64'd0, 64'd1);
          end else begin
            mon_exp = exp_q.pop_front();
            for (int i = 0; i < 4; i++)
              chk($sformatf("slot%0d {an,seg,dp,shape}", i),
                  {obs[i], shape_ok[i]}, {mon_exp[i], 1'b1});
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc != c) @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    upd_bus.upd_valid = 1'b1;
    upd_bus.upd_value = v;
    upd_bus.upd_dp    = d;
    upd_bus.upd_blank = b;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " an"}, an, 4'hF);
    chk({tag, " seg"}, seg, 7'h7F);
    chk({tag, " dp"}, dp, 1'b1);
    chk({tag, " frame_done"}, frame_done, 1'b0);
    chk({tag, " upd_ready"}, upd_bus.upd_ready, 1'b1);
  endtask

  localparam frame_t F_DARK = {DARK, DARK, DARK, DARK};

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    frame_t f1234, f5678, f9abc, ffedc, fdpbl, f0050;
    f1234 = mk(sl(4'hE, 7'h19, 1'b1), sl(4'hD, 7'h30, 1'b1), sl(4'hB, 7'h24, 1'b1), sl(4'h7, 7'h79, 1'b1));
    f5678 = mk(sl(4'hE, 7'h00, 1'b1), sl(4'hD, 7'h78, 1'b1), sl(4'hB, 7'h02, 1'b1), sl(4'h7, 7'h12, 1'b1));
    f9abc = mk(sl(4'hE, 7'h46, 1'b1), sl(4'hD, 7'h03, 1'b1), sl(4'hB, 7'h08, 1'b1), sl(4'h7, 7'h10, 1'b1));
    ffedc = mk(sl(4'hE, 7'h46, 1'b1), sl(4'hD, 7'h21, 1'b1), sl(4'hB, 7'h06, 1'b1), sl(4'h7, 7'h0E, 1'b1));
    fdpbl = mk(sl(4'hE, 7'h19, 1'b1), sl(4'hD, 7'h30, 1'b1), sl(4'hB, 7'h24, 1'b0), DARK);
`ifdef SEG7_LZS_EN
    f0050 = mk(sl(4'hE, 7'h40, 1'b1), sl(4'hD, 7'h12, 1'b1), DARK, DARK);
`else
    f0050 = mk(sl(4'hE, 7'h40, 1'b1), sl(4'hD, 7'h12, 1'b1), sl(4'hB, 7'h40, 1'b1), sl(4'h7, 7'h40, 1'b1));
`endif

    upd_bus.upd_valid = 1'b0;
    upd_bus.upd_value = 16'h0000;
    upd_bus.upd_dp    = 4'h0;
    upd_bus.upd_blank = 4'h0;

    // 1: reset values, then three dark frames
    #12;
    chk_reset_vals("reset");
    repeat (3) exp_q.push_back(F_DARK);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // 2: load 1234 during frame 2, shown from frame 3
    wait_cyc(70);
    drive(16'h1234, 4'h0, 4'h0);
    exp_q.push_back(f1234);
    wait_cyc(71);
    upd_bus.upd_valid = 1'b0;
    chk("ready after accept", upd_bus.upd_ready, 1'b0);
    wait_cyc(95);
    chk("ready on wrap cycle", upd_bus.upd_ready, 1'b0);
    wait_cyc(96);
    chk("ready after wrap", upd_bus.upd_ready, 1'b1);

    // 3: valid held through a frame; second value waits for ready
    wait_cyc(106);
    drive(16'h5678, 4'h0, 4'h0);
    exp_q.push_back(f5678);
    exp_q.push_back(f9abc);
    wait_cyc(107);
    upd_bus.upd_value = 16'h9ABC;
    for (int c = 107; c < 128; c++) begin
      wait_cyc(c);
      chk("ready low while shadow full", upd_bus.upd_ready, 1'b0);
    end
    wait_cyc(128);
    chk("ready back after wrap", upd_bus.upd_ready, 1'b1);
    wait_cyc(129);
    chk("second value accepted", upd_bus.upd_ready, 1'b0);
    upd_bus.upd_valid = 1'b0;

    // 4: accept on the wrap cycle itself is deferred by one frame
    wait_cyc(191);
    chk("ready before wrap accept", upd_bus.upd_ready, 1'b1);
    drive(16'hFEDC, 4'h0, 4'h0);
    exp_q.push_back(f9abc);
    exp_q.push_back(ffedc);
    wait_cyc(192);
    upd_bus.upd_valid = 1'b0;
    chk("ready after wrap accept", upd_bus.upd_ready, 1'b0);
    wait_cyc(223);
    chk("ready held until next wrap", upd_bus.upd_ready, 1'b0);
    wait_cyc(224);
    chk("ready after deferred apply", upd_bus.upd_ready, 1'b1);

    // 5: decimal point on AN2 only, AN3 blanked
    wait_cyc(230);
    drive(16'h1234, 4'b0100, 4'b1000);
    exp_q.push_back(fdpbl);
    wait_cyc(231);
    upd_bus.upd_valid = 1'b0;

    // 7: value 0050 (leading-zero suppression when enabled)
    wait_cyc(262);
    drive(16'h0050, 4'h0, 4'h0);
    exp_q.push_back(f0050);
    wait_cyc(263);
    upd_bus.upd_valid = 1'b0;

    // 6: reset mid-DRIVE with a pending shadow
    wait_cyc(292);
    drive(16'h1234, 4'h0, 4'h0);
    wait_cyc(293);
    upd_bus.upd_valid = 1'b0;
    chk("shadow pending before reset", upd_bus.upd_ready, 1'b0);
    wait_cyc(300);
    chk("an driven before reset", an, 4'hD);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("mid-frame reset");
    exp_q.delete();
    repeat (2) exp_q.push_back(F_DARK);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_cyc(10);
    chk("ready after reset release", upd_bus.upd_ready, 1'b1);
    wait_cyc(2 * FRAME + 1);
    chk("all expected frames checked", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
